// File: rtl/best_neighbor_scan_pkg.sv
// Shared constants and FSM encoding for the neighbor Q-table scanner.
package best_neighbor_scan_pkg;

  localparam logic [15:0] FP16_POS_INF = 16'h7C00;
  localparam logic [15:0] NO_NODE      = 16'hFFFF;

  localparam int unsigned ENTRY_WORDS = 3;
  localparam logic [1:0]  WORD_ID     = 2'd0;
  localparam logic [1:0]  WORD_Q      = 2'd1;
  localparam logic [1:0]  WORD_ADV    = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StFinish
  } state_e;

endpackage

// File: rtl/best_neighbor_scan_if.sv
// Table-memory read port between the scanner (master) and the shared table memory (slave).
interface best_neighbor_scan_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned WORD_WIDTH = 16
) ();

  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_WIDTH-1:0] mem_rd_data;

  modport master (
    output mem_rd_en,
    output mem_addr,
    input  mem_rd_data
  );

  modport slave (
    input  mem_rd_en,
    input  mem_addr,
    output mem_rd_data
  );

endinterface

// File: rtl/best_neighbor_scan_fp16_less_than.sv
// Combinational IEEE-754 binary16 strict less-than; NaN never compares less, +0 == -0.
module fp16_less_than (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        less
);

  logic a_nan;
  logic b_nan;
  logic both_zero;

  always_comb begin
    a_nan     = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
    b_nan     = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
    both_zero = (a[14:0] == 15'd0) && (b[14:0] == 15'd0);
    if (a_nan || b_nan || both_zero) begin
      less = 1'b0;
    end else if (a[15] != b[15]) begin
      less = a[15];
    end else if (!a[15]) begin
      less = a[14:0] < b[14:0];
    end else begin
      // Both negative: larger magnitude is the smaller value.
      less = a[14:0] > b[14:0];
    end
  end

endmodule

// File: rtl/best_neighbor_scan.sv
// Scans a neighbor Q-table and reports the local and advertised minima with a one-cycle done.
// Optional: define SKIP_SELF_EN to drop this node's own entry from the advertised-minimum search.
module best_neighbor_scan
  import best_neighbor_scan_pkg::*;
#(
  parameter int unsigned MAX_NEIGHBORS = 64,
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned WORD_WIDTH    = 16
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic [15:0]           neighbor_count,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [WORD_WIDTH-1:0] MY_NODE_ID,
  best_neighbor_scan_if.master  mem,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] mybest,
  output logic [WORD_WIDTH-1:0] besthop,
  output logic [WORD_WIDTH-1:0] bestvalue,
  output logic [WORD_WIDTH-1:0] bestneighborID
);

`ifdef SKIP_SELF_EN
  localparam bit SkipSelf = 1'b1;
`else
  localparam bit SkipSelf = 1'b0;
`endif

  state_e                state_q;
  logic                  rd_en_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           reads_left_q;
  logic                  valid_q;
  logic [1:0]            phase_q;
  logic [WORD_WIDTH-1:0] cur_id_q, cur_q_q, my_id_q;
  logic [WORD_WIDTH-1:0] mb_q, hop_q, bv_q, bid_q;
  logic [WORD_WIDTH-1:0] mb_d, hop_d, bv_d, bid_d;
  logic [15:0]           n_clamp, reads_init;
  logic                  adv_word, is_self, q_less, adv_less;

  assign mem.mem_rd_en = rd_en_q;
  assign mem.mem_addr  = addr_q;

  fp16_less_than u_q_lt (
    .a    (cur_q_q),
    .b    (mb_q),
    .less (q_less)
  );

  fp16_less_than u_adv_lt (
    .a    (mem.mem_rd_data),
    .b    (bv_q),
    .less (adv_less)
  );

  always_comb begin
    n_clamp    = (neighbor_count > 16'(MAX_NEIGHBORS)) ? 16'(MAX_NEIGHBORS) : neighbor_count;
    reads_init = n_clamp * 16'(ENTRY_WORDS) - 16'd1;
    // The advertised word is on the bus this cycle; ID and Q were captured on earlier cycles.
    adv_word   = valid_q && (phase_q == WORD_ADV);
    is_self    = (cur_id_q == my_id_q);
    mb_d       = mb_q;
    hop_d      = hop_q;
    bv_d       = bv_q;
    bid_d      = bid_q;
    if (adv_word && q_less) begin
      mb_d  = cur_q_q;
      hop_d = cur_id_q;
    end
    if (adv_word && adv_less && !(SkipSelf && is_self)) begin
      bv_d  = mem.mem_rd_data;
      bid_d = cur_id_q;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q        <= StIdle;
      rd_en_q        <= 1'b0;
      addr_q         <= '0;
      reads_left_q   <= '0;
      valid_q        <= 1'b0;
      phase_q        <= WORD_ID;
      cur_id_q       <= '0;
      cur_q_q        <= '0;
      my_id_q        <= '0;
      mb_q           <= WORD_WIDTH'(FP16_POS_INF);
      hop_q          <= WORD_WIDTH'(NO_NODE);
      bv_q           <= WORD_WIDTH'(FP16_POS_INF);
      bid_q          <= WORD_WIDTH'(NO_NODE);
      busy           <= 1'b0;
      done           <= 1'b0;
      mybest         <= WORD_WIDTH'(FP16_POS_INF);
      besthop        <= WORD_WIDTH'(NO_NODE);
      bestvalue      <= WORD_WIDTH'(FP16_POS_INF);
      bestneighborID <= WORD_WIDTH'(NO_NODE);
    end else begin
      valid_q <= rd_en_q;
      if (valid_q) begin
        phase_q <= (phase_q == WORD_ADV) ? WORD_ID : phase_q + 2'd1;
        if (phase_q == WORD_ID) cur_id_q <= mem.mem_rd_data;
        if (phase_q == WORD_Q)  cur_q_q  <= mem.mem_rd_data;
      end
      mb_q  <= mb_d;
      hop_q <= hop_d;
      bv_q  <= bv_d;
      bid_q <= bid_d;

      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            busy    <= 1'b1;
            my_id_q <= MY_NODE_ID;
            phase_q <= WORD_ID;
            mb_q    <= WORD_WIDTH'(FP16_POS_INF);
            hop_q   <= WORD_WIDTH'(NO_NODE);
            bv_q    <= WORD_WIDTH'(FP16_POS_INF);
            bid_q   <= WORD_WIDTH'(NO_NODE);
            if (n_clamp == 16'd0) begin
              state_q        <= StFinish;
              done           <= 1'b1;
              mybest         <= WORD_WIDTH'(FP16_POS_INF);
              besthop        <= WORD_WIDTH'(NO_NODE);
              bestvalue      <= WORD_WIDTH'(FP16_POS_INF);
              bestneighborID <= WORD_WIDTH'(NO_NODE);
            end else begin
              state_q      <= StFetch;
              rd_en_q      <= 1'b1;
              addr_q       <= base_addr;
              reads_left_q <= reads_init;
            end
          end
        end
        StFetch: begin
          if (reads_left_q == 16'd0) begin
            rd_en_q <= 1'b0;
            state_q <= StDrain;
          end else begin
            addr_q       <= addr_q + ADDR_WIDTH'(1);
            reads_left_q <= reads_left_q - 16'd1;
          end
        end
        StDrain: begin
          // Last advertised word is on the bus now, so publish the post-update minima.
          state_q        <= StFinish;
          done           <= 1'b1;
          mybest         <= mb_d;
          besthop        <= hop_d;
          bestvalue      <= bv_d;
          bestneighborID <= bid_d;
        end
        StFinish: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_best_neighbor_scan.sv
// Self-checking bench for best_neighbor_scan: directed scenarios plus randomized scans vs a real-valued model.
module tb_best_neighbor_scan;

  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] neighbor_count = 16'd0;
  logic [9:0]  base_addr = 10'd0;
  logic [15:0] my_node_id = 16'd0;
  logic        busy, done;
  logic [15:0] mybest, besthop, bestvalue, bestneighborID;

  logic [15:0] mem_arr [1024];
  int          rd_count = 0;
  bit          prev_en = 1'b0;
  logic [9:0]  prev_addr = 10'd0;
  bit          wrap_seen = 1'b0;

  int total = 0;
  int fails = 0;

  always #5 clock = ~clock;

  best_neighbor_scan_if #(.ADDR_WIDTH(10), .WORD_WIDTH(16)) mem_bus ();

  best_neighbor_scan #(
    .MAX_NEIGHBORS (64),
    .ADDR_WIDTH    (10),
    .WORD_WIDTH    (16)
  ) dut (
    .clock          (clock),
    .nreset         (nreset),
    .start          (start),
    .neighbor_count (neighbor_count),
    .base_addr      (base_addr),
    .MY_NODE_ID     (my_node_id),
    .mem            (mem_bus),
    .busy           (busy),
    .done           (done),
    .mybest         (mybest),
    .besthop        (besthop),
    .bestvalue      (bestvalue),
    .bestneighborID (bestneighborID)
  );

  // Table memory: one-cycle read latency.
  always @(posedge clock) begin
    if (mem_bus.mem_rd_en) mem_bus.mem_rd_data <= mem_arr[mem_bus.mem_addr];
    if (mem_bus.mem_rd_en) rd_count <= rd_count + 1;
    if (prev_en && mem_bus.mem_rd_en && prev_addr == 10'd1023 && mem_bus.mem_addr == 10'd0)
      wrap_seen <= 1'b1;
    prev_en   <= mem_bus.mem_rd_en;
    prev_addr <= mem_bus.mem_addr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_nan(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] != 10'd0);
  endfunction

  function automatic real to_real(input logic [15:0] h);
    real mag;
    int  sc;
    int  e;
    e = int'(h[14:10]);
    if (e == 31) begin
      mag = 1.0e300;
    end else begin
      mag = (e == 0) ? real'(int'(h[9:0])) : real'(1024 + int'(h[9:0]));
      sc  = (e == 0) ? -24 : e - 25;
      while (sc > 0) begin mag = mag * 2.0; sc--; end
      while (sc < 0) begin mag = mag / 2.0; sc++; end
    end
    return h[15] ? -mag : mag;
  endfunction

  function automatic bit fp_lt(input logic [15:0] a, input logic [15:0] b);
    if (is_nan(a) || is_nan(b)) return 1'b0;
    return to_real(a) < to_real(b);
  endfunction

  function automatic void model(input int cnt, input int base, input logic [15:0] myid,
                                output logic [15:0] mb, output logic [15:0] hop,
                                output logic [15:0] bv, output logic [15:0] bid);
    int n;
    logic [15:0] id, q, adv;
    bit skip;
    mb = 16'h7C00; hop = 16'hFFFF; bv = 16'h7C00; bid = 16'hFFFF;
    n = (cnt > 64) ? 64 : cnt;
    for (int i = 0; i < n; i++) begin
      id  = mem_arr[(base + 3 * i) % 1024];
      q   = mem_arr[(base + 3 * i + 1) % 1024];
      adv = mem_arr[(base + 3 * i + 2) % 1024];
      if (fp_lt(q, mb)) begin mb = q; hop = id; end
      skip = 1'b0;
`ifdef SKIP_SELF_EN
      skip = (id == myid);
`endif
      if (!skip && fp_lt(adv, bv)) begin bv = adv; bid = id; end
    end
  endfunction

  function automatic logic [15:0] rnd_fp16();
    case ($urandom_range(0, 9))
      0: return 16'h0000;
      1: return 16'h8000;
      2: return 16'h7C00;
      3: return 16'h7E00;
      4: return 16'h3C00;
      5: return 16'hBC00;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, ".rd_en"}, 32'(mem_bus.mem_rd_en), 32'd0);
    check({tag, ".addr"}, 32'(mem_bus.mem_addr), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".mybest"}, 32'(mybest), 32'h7C00);
    check({tag, ".besthop"}, 32'(besthop), 32'hFFFF);
    check({tag, ".bestvalue"}, 32'(bestvalue), 32'h7C00);
    check({tag, ".bestnbr"}, 32'(bestneighborID), 32'hFFFF);
  endtask

  task automatic do_scan(input string tag, input int cnt, input int base,
                         input logic [15:0] myid, input bit hold_start);
    logic [15:0] emb, ehop, ebv, ebid;
    int k, rd0, n;
    model(cnt, base, myid, emb, ehop, ebv, ebid);
    n = (cnt > 64) ? 64 : cnt;
    @(negedge clock);
    neighbor_count = 16'(cnt);
    base_addr      = 10'(base);
    my_node_id     = myid;
    start          = 1'b1;
    rd0            = rd_count;
    @(negedge clock);
    if (!hold_start) start = 1'b0;
    check({tag, ".busy"}, 32'(busy), 32'd1);
    k = 1;
    while (!done && k < 300) begin
      @(negedge clock);
      k++;
    end
    check({tag, ".latency"}, done ? 32'(k) : 32'd0, (n == 0) ? 32'd1 : 32'(3 * n + 2));
    check({tag, ".reads"}, 32'(rd_count - rd0), 32'(3 * n));
    check({tag, ".mybest"}, 32'(mybest), 32'(emb));
    check({tag, ".besthop"}, 32'(besthop), 32'(ehop));
    check({tag, ".bestvalue"}, 32'(bestvalue), 32'(ebv));
    check({tag, ".bestnbr"}, 32'(bestneighborID), 32'(ebid));
    start = 1'b0;
    @(negedge clock);
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic put_entry(input int addr, input logic [15:0] id, input logic [15:0] q,
                           input logic [15:0] adv);
    mem_arr[addr % 1024]       = id;
    mem_arr[(addr + 1) % 1024] = q;
    mem_arr[(addr + 2) % 1024] = adv;
  endtask

  initial begin
    bit done_seen;
    for (int i = 0; i < 1024; i++) mem_arr[i] = rnd_fp16();

    // Reset state
    repeat (2) @(negedge clock);
    check_reset_vals("reset");
    nreset = 1'b1;

    // Basic minima
    put_entry(0, 16'd5, 16'h4000, 16'h3C00);
    put_entry(3, 16'd7, 16'h3800, 16'h4000);
    put_entry(6, 16'd9, 16'h3C00, 16'h3800);
    do_scan("basic", 3, 0, 16'd0, 1'b0);
    check("basic.lit_mybest", 32'(mybest), 32'h3800);
    check("basic.lit_besthop", 32'(besthop), 32'd7);
    check("basic.lit_bestvalue", 32'(bestvalue), 32'h3800);
    check("basic.lit_bestnbr", 32'(bestneighborID), 32'd9);

    // Ties keep the earlier entry; negative value wins
    put_entry(100, 16'd2, 16'h3C00, 16'h4000);
    put_entry(103, 16'd4, 16'h3C00, 16'h4000);
    put_entry(106, 16'd6, 16'hBC00, 16'h4000);
    do_scan("neg", 3, 100, 16'd0, 1'b0);
    check("neg.lit_besthop", 32'(besthop), 32'd6);
    do_scan("tie", 2, 100, 16'd0, 1'b0);
    check("tie.lit_besthop", 32'(besthop), 32'd2);
    check("tie.lit_bestnbr", 32'(bestneighborID), 32'd2);

    // Empty table
    do_scan("empty", 0, 0, 16'd0, 1'b0);
    check("empty.lit_mybest", 32'(mybest), 32'h7C00);
    check("empty.lit_bestnbr", 32'(bestneighborID), 32'hFFFF);

    // NaN-only entry
    put_entry(200, 16'd11, 16'h7E00, 16'h7E00);
    do_scan("nan", 1, 200, 16'd0, 1'b0);
    check("nan.lit_mybest", 32'(mybest), 32'h7C00);
    check("nan.lit_besthop", 32'(besthop), 32'hFFFF);

    // Clamp and address wrap
    do_scan("clamp", 100, 1020, 16'd0, 1'b0);
    check("clamp.wrap", 32'(wrap_seen), 32'd1);

    // Self entry holds the lowest advertised value
    put_entry(300, 16'd1, 16'h4400, 16'h3800);
    put_entry(303, 16'd3, 16'h4200, 16'h3000);
    put_entry(306, 16'd8, 16'h4600, 16'h3400);
    do_scan("self", 3, 300, 16'd3, 1'b0);
    check("self.lit_besthop", 32'(besthop), 32'd3);
`ifdef SKIP_SELF_EN
    check("self.lit_bestnbr", 32'(bestneighborID), 32'd8);
`else
    check("self.lit_bestnbr", 32'(bestneighborID), 32'd3);
`endif

    // Randomized scans
    for (int i = 0; i < 1024; i++) mem_arr[i] = rnd_fp16();
    for (int r = 0; r < 8; r++) begin
      do_scan($sformatf("rand%0d", r), int'($urandom_range(0, 12)), int'($urandom_range(0, 1023)),
              16'($urandom_range(0, 15)), 1'b0);
    end

    // start held through the scan: no restart, no extra reads
    put_entry(0, 16'd5, 16'h4000, 16'h3C00);
    put_entry(3, 16'd7, 16'h3800, 16'h4000);
    put_entry(6, 16'd9, 16'h3C00, 16'h3800);
    do_scan("hold", 3, 0, 16'd0, 1'b1);
    repeat (3) @(negedge clock);
    check("hold.idle_rd_en", 32'(mem_bus.mem_rd_en), 32'd0);

    // Reset in cycle T+4 of a scan aborts it
    @(negedge clock);
    neighbor_count = 16'd10;
    base_addr      = 10'd0;
    start          = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    check("abort.rd_en_before", 32'(mem_bus.mem_rd_en), 32'd1);
    nreset = 1'b0;
    #1;
    check_reset_vals("abort");
    @(negedge clock);
    nreset = 1'b1;
    done_seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (done || mem_bus.mem_rd_en) done_seen = 1'b1;
    end
    check("abort.no_done", 32'(done_seen), 32'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
